// File: rtl/switch_allocator_rr_if.sv
// Request/grant bundle between the VC-allocation stage and the switch allocator.
// slave = allocator side, master = request source / crossbar side.
interface switch_allocator_rr_if #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VC    = 4,
  parameter int PORT_BITS = $clog2(NUM_PORTS),
  parameter int VC_BITS   = $clog2(NUM_VC)
);
  logic [NUM_PORTS*NUM_VC-1:0]           sa_req;
  logic [NUM_PORTS*NUM_VC*NUM_PORTS-1:0] sa_req_dst;
  logic [NUM_PORTS*NUM_VC-1:0]           sa_req_tail;
  logic [NUM_PORTS-1:0]                  out_ready;
  logic [NUM_PORTS-1:0]                  sa_grant_valid;
  logic [NUM_PORTS*VC_BITS-1:0]          sa_grant_vc;
  logic [NUM_PORTS*NUM_PORTS-1:0]        sa_allocated_ports;
  logic [NUM_PORTS-1:0]                  xbar_valid;
  logic [NUM_PORTS*PORT_BITS-1:0]        xbar_sel;

  modport master (
    output sa_req, sa_req_dst, sa_req_tail, out_ready,
    input  sa_grant_valid, sa_grant_vc, sa_allocated_ports, xbar_valid, xbar_sel
  );

  modport slave (
    input  sa_req, sa_req_dst, sa_req_tail, out_ready,
    output sa_grant_valid, sa_grant_vc, sa_allocated_ports, xbar_valid, xbar_sel
  );
endinterface

// File: rtl/switch_allocator_rr.sv
// Separable input-first round-robin switch allocator with registered grants.
// Optional packet locking of output ports is enabled by defining SA_PACKET_LOCK_EN.
module switch_allocator_rr #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VC    = 4,
  parameter int PORT_BITS = $clog2(NUM_PORTS),
  parameter int VC_BITS   = $clog2(NUM_VC)
) (
  input logic                  clk,
  input logic                  reset,
  switch_allocator_rr_if.slave sa
);

  function automatic int wrapAdd(input int base, input int k, input int m);
    int s;
    s = base + k;
    if (s >= m) s = s - m;
    return s;
  endfunction

  logic [NUM_PORTS-1:0] w_dst       [NUM_PORTS][NUM_VC];
  logic [NUM_VC-1:0]    w_elig      [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_candValid;
  logic [VC_BITS-1:0]   w_candVc    [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_candDst   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_allowed   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_win;
  logic [PORT_BITS-1:0] w_winPort   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt;

  logic [VC_BITS-1:0]             r_inPtr  [NUM_PORTS];
  logic [PORT_BITS-1:0]           r_outPtr [NUM_PORTS];
  logic [NUM_PORTS-1:0]           r_grantValid;
  logic [NUM_PORTS*VC_BITS-1:0]   r_grantVc;
  logic [NUM_PORTS*NUM_PORTS-1:0] r_alloc;
  logic [NUM_PORTS-1:0]           r_xbarValid;
  logic [NUM_PORTS*PORT_BITS-1:0] r_xbarSel;

`ifdef SA_PACKET_LOCK_EN
  logic [NUM_PORTS-1:0] r_lockValid;
  logic [PORT_BITS-1:0] r_lockPort [NUM_PORTS];
  logic [VC_BITS-1:0]   r_lockVc   [NUM_PORTS];
`else
  logic w_unusedTail;
  assign w_unusedTail = ^sa.sa_req_tail;
`endif

  // A request counts only with a one-hot destination whose output has credit.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        w_dst[p][v]  = sa.sa_req_dst[(p*NUM_VC+v)*NUM_PORTS +: NUM_PORTS];
        w_elig[p][v] = sa.sa_req[p*NUM_VC+v] && $onehot(w_dst[p][v]) &&
                       (|(w_dst[p][v] & sa.out_ready));
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_candValid[p] = 1'b0;
      w_candVc[p]    = '0;
      for (int k = 0; k < NUM_VC; k++) begin
        if (!w_candValid[p] && w_elig[p][wrapAdd(int'(r_inPtr[p]), k, NUM_VC)]) begin
          w_candValid[p] = 1'b1;
          w_candVc[p]    = VC_BITS'(wrapAdd(int'(r_inPtr[p]), k, NUM_VC));
        end
      end
`ifdef SA_PACKET_LOCK_EN
      // A lock owner keeps presenting its locked VC while that VC is eligible.
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (r_lockValid[o] && r_lockPort[o] == PORT_BITS'(p) && w_elig[p][r_lockVc[o]]) begin
          w_candValid[p] = 1'b1;
          w_candVc[p]    = r_lockVc[o];
        end
      end
`endif
      w_candDst[p] = w_dst[p][w_candVc[p]];
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_allowed[o] = '1;
`ifdef SA_PACKET_LOCK_EN
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_lockValid[o])
          w_allowed[o][p] = (r_lockPort[o] == PORT_BITS'(p)) && (w_candVc[p] == r_lockVc[o]);
      end
`endif
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_win[o]     = 1'b0;
      w_winPort[o] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!w_win[o] && w_candValid[wrapAdd(int'(r_outPtr[o]), k, NUM_PORTS)] &&
            w_candDst[wrapAdd(int'(r_outPtr[o]), k, NUM_PORTS)][o] &&
            w_allowed[o][wrapAdd(int'(r_outPtr[o]), k, NUM_PORTS)]) begin
          w_win[o]     = 1'b1;
          w_winPort[o] = PORT_BITS'(wrapAdd(int'(r_outPtr[o]), k, NUM_PORTS));
        end
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_win[o] && w_winPort[o] == PORT_BITS'(p)) w_gnt[p] = 1'b1;
      end
    end
  end

  // Pointers advance only past a stage-2 winner, so losers keep their priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grantValid <= '0;
      r_grantVc    <= '0;
      r_alloc      <= '0;
      r_xbarValid  <= '0;
      r_xbarSel    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_inPtr[i]  <= '0;
        r_outPtr[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_grantValid[p]                     <= w_gnt[p];
        r_grantVc[p*VC_BITS +: VC_BITS]     <= w_gnt[p] ? w_candVc[p] : '0;
        r_alloc[p*NUM_PORTS +: NUM_PORTS]   <= w_gnt[p] ? w_candDst[p] : '0;
        if (w_gnt[p]) r_inPtr[p] <= VC_BITS'(wrapAdd(int'(w_candVc[p]), 1, NUM_VC));
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_xbarValid[o]                      <= w_win[o];
        r_xbarSel[o*PORT_BITS +: PORT_BITS] <= w_win[o] ? w_winPort[o] : '0;
        if (w_win[o]) r_outPtr[o] <= PORT_BITS'(wrapAdd(int'(w_winPort[o]), 1, NUM_PORTS));
      end
    end
  end

`ifdef SA_PACKET_LOCK_EN
  // Every grant on an output rewrites its lock: held for a non-tail flit, dropped on a tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lockValid <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_lockPort[o] <= '0;
        r_lockVc[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_win[o]) begin
          r_lockValid[o] <= ~sa.sa_req_tail[int'(w_winPort[o])*NUM_VC + int'(w_candVc[w_winPort[o]])];
          r_lockPort[o]  <= w_winPort[o];
          r_lockVc[o]    <= w_candVc[w_winPort[o]];
        end
      end
    end
  end
`endif

  assign sa.sa_grant_valid     = r_grantValid;
  assign sa.sa_grant_vc        = r_grantVc;
  assign sa.sa_allocated_ports = r_alloc;
  assign sa.xbar_valid         = r_xbarValid;
  assign sa.xbar_sel           = r_xbarSel;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Bench for switch_allocator_rr: directed scenarios plus randomized traffic against
// a distance-based round-robin model (follows SA_PACKET_LOCK_EN like the design).
module tb_switch_allocator_rr;
  localparam int NP = 5;
  localparam int NV = 4;
  localparam int PB = 3;
  localparam int VB = 2;

  logic clk = 1'b0;
  logic reset;

  switch_allocator_rr_if #(.NUM_PORTS(NP), .NUM_VC(NV)) sif ();

  switch_allocator_rr #(.NUM_PORTS(NP), .NUM_VC(NV)) dut (
    .clk   (clk),
    .reset (reset),
    .sa    (sif)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic          tReq  [NP][NV];
  logic [NP-1:0] tDst  [NP][NV];
  logic          tTail [NP][NV];
  logic [NP-1:0] tReady;

  int mInPtr [NP];
  int mOutPtr[NP];
  bit mLockV [NP];
  int mLockP [NP];
  int mLockVc[NP];

  bit eGv [NP];
  int eVc [NP];
  int eDst[NP];
  bit eXv [NP];
  int eSel[NP];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clearStimulus();
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++) begin
        tReq[p][v]  = 1'b0;
        tDst[p][v]  = '0;
        tTail[p][v] = 1'b1;
      end
    tReady = '1;
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++) begin
        sif.sa_req[p*NV+v]                  = tReq[p][v];
        sif.sa_req_dst[(p*NV+v)*NP +: NP]   = tDst[p][v];
        sif.sa_req_tail[p*NV+v]             = tTail[p][v];
      end
    sif.out_ready = tReady;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NP; i++) begin
      mInPtr[i] = 0; mOutPtr[i] = 0; mLockV[i] = 0; mLockP[i] = 0; mLockVc[i] = 0;
      eGv[i] = 0; eVc[i] = 0; eDst[i] = 0; eXv[i] = 0; eSel[i] = 0;
    end
  endtask

  // Winner = smallest round-robin distance from the pointer among eligible contenders.
  task automatic modelStep();
    int dIdx [NP][NV];
    bit ok   [NP][NV];
    int cand [NP];
    int best, d, win;
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++) begin
        dIdx[p][v] = -1;
        if ($countones(tDst[p][v]) == 1)
          for (int o = 0; o < NP; o++) if (tDst[p][v][o]) dIdx[p][v] = o;
        ok[p][v] = tReq[p][v] && (dIdx[p][v] >= 0);
        if (ok[p][v]) ok[p][v] = tReady[dIdx[p][v]];
      end
    for (int p = 0; p < NP; p++) begin
      cand[p] = -1;
      best = NV;
      for (int v = 0; v < NV; v++) begin
        d = (v - mInPtr[p] + NV) % NV;
        if (ok[p][v] && d < best) begin best = d; cand[p] = v; end
      end
`ifdef SA_PACKET_LOCK_EN
      for (int o = 0; o < NP; o++)
        if (mLockV[o] && mLockP[o] == p && ok[p][mLockVc[o]]) cand[p] = mLockVc[o];
`endif
    end
    for (int i = 0; i < NP; i++) begin
      eGv[i] = 0; eVc[i] = 0; eDst[i] = 0; eXv[i] = 0; eSel[i] = 0;
    end
    for (int o = 0; o < NP; o++) begin
      win = -1;
      best = NP;
      for (int p = 0; p < NP; p++) begin
        if (cand[p] < 0) continue;
        if (dIdx[p][cand[p]] != o) continue;
`ifdef SA_PACKET_LOCK_EN
        if (mLockV[o] && !(mLockP[o] == p && mLockVc[o] == cand[p])) continue;
`endif
        d = (p - mOutPtr[o] + NP) % NP;
        if (d < best) begin best = d; win = p; end
      end
      if (win >= 0) begin
        eXv[o] = 1; eSel[o] = win;
        eGv[win] = 1; eVc[win] = cand[win]; eDst[win] = o;
        mInPtr[win] = (cand[win] + 1) % NV;
        mOutPtr[o]  = (win + 1) % NP;
`ifdef SA_PACKET_LOCK_EN
        mLockV[o] = !tTail[win][cand[win]];
        mLockP[o] = win;
        mLockVc[o] = cand[win];
`endif
      end
    end
  endtask

  task automatic compareAll();
    int cnt;
    for (int p = 0; p < NP; p++) begin
      checkOutput($sformatf("grant_valid[%0d]", p), 32'(sif.sa_grant_valid[p]), 32'(eGv[p]));
      checkOutput($sformatf("grant_vc[%0d]", p), 32'(sif.sa_grant_vc[p*VB +: VB]),
                  eGv[p] ? eVc[p] : 0);
      checkOutput($sformatf("allocated_ports[%0d]", p), 32'(sif.sa_allocated_ports[p*NP +: NP]),
                  eGv[p] ? (32'd1 << eDst[p]) : 32'd0);
    end
    for (int o = 0; o < NP; o++) begin
      checkOutput($sformatf("xbar_valid[%0d]", o), 32'(sif.xbar_valid[o]), 32'(eXv[o]));
      checkOutput($sformatf("xbar_sel[%0d]", o), 32'(sif.xbar_sel[o*PB +: PB]),
                  eXv[o] ? eSel[o] : 0);
      cnt = 0;
      for (int p = 0; p < NP; p++) cnt += int'(sif.sa_allocated_ports[p*NP+o]);
      checkOutput($sformatf("grants_on_output[%0d]>1", o), 32'(cnt > 1), 32'd0);
    end
  endtask

  // Called at a negedge; returns at the next negedge after checking the edge's result.
  task automatic cycle();
    @(posedge clk);
    if (reset) modelReset();
    else modelStep();
    #1;
    compareAll();
    @(negedge clk);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    cycle();
    reset = 1'b0;
  endtask

  logic [31:0] seqA [8];

  initial begin
    reset = 1'b1;
    clearStimulus();
    applyStimulus();
    modelReset();
    @(negedge clk);
    cycle();
    reset = 1'b0;

    // Reset mid-grant, then one request p1v0->o2 granted one edge later
    tReq[1][0] = 1'b1; tDst[1][0] = 5'b00100;
    applyStimulus();
    cycle();
    checkOutput("t1 grant before reset", 32'(sif.sa_grant_valid[1]), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t1 grant_valid in reset", 32'(sif.sa_grant_valid), 32'd0);
    checkOutput("t1 xbar_valid in reset", 32'(sif.xbar_valid), 32'd0);
    checkOutput("t1 alloc in reset", 32'(sif.sa_allocated_ports), 32'd0);
    modelReset();
    compareAll();
    cycle();
    reset = 1'b0;
    checkOutput("t1 no grant before edge", 32'(sif.sa_grant_valid), 32'd0);
    cycle();
    checkOutput("t1 grant_valid[1]", 32'(sif.sa_grant_valid[1]), 32'd1);
    checkOutput("t1 grant_vc[1]", 32'(sif.sa_grant_vc[1*VB +: VB]), 32'd0);
    checkOutput("t1 xbar_sel[2]", 32'(sif.xbar_sel[2*PB +: PB]), 32'd1);

    // Inputs 1..4 contend for output 3
    pulseReset();
    clearStimulus();
    for (int p = 1; p < NP; p++) begin tReq[p][0] = 1'b1; tDst[p][0] = 5'b01000; end
    applyStimulus();
    seqA = '{1, 2, 3, 4, 1, 2, 3, 4};
    for (int k = 0; k < 8; k++) begin
      cycle();
      checkOutput($sformatf("t2 xbar_sel[3] step%0d", k), 32'(sif.xbar_sel[3*PB +: PB]), seqA[k]);
      checkOutput($sformatf("t2 one grant step%0d", k), 32'($countones(sif.sa_grant_valid)), 32'd1);
    end

    // Input 2 rotates through all VCs
    pulseReset();
    clearStimulus();
    for (int v = 0; v < NV; v++) begin tReq[2][v] = 1'b1; tDst[2][v] = NP'(1 << v); end
    applyStimulus();
    for (int k = 0; k < 5; k++) begin
      cycle();
      checkOutput($sformatf("t3 grant_vc[2] step%0d", k), 32'(sif.sa_grant_vc[2*VB +: VB]), k % NV);
    end

    // Output without credit is skipped, then served once ready
    pulseReset();
    clearStimulus();
    tReq[0][1] = 1'b1; tDst[0][1] = 5'b10000;
    tReq[0][2] = 1'b1; tDst[0][2] = 5'b00010;
    tReady = 5'b01111;
    applyStimulus();
    cycle();
    checkOutput("t4 grant_vc[0] blocked", 32'(sif.sa_grant_vc[0 +: VB]), 32'd2);
    tReady = 5'b11111;
    applyStimulus();
    cycle();
    checkOutput("t4 grant_valid[0] ready", 32'(sif.sa_grant_valid[0]), 32'd1);
    checkOutput("t4 grant_vc[0] ready", 32'(sif.sa_grant_vc[0 +: VB]), 32'd1);

    // Malformed destinations are ignored and leave pointers alone
    pulseReset();
    clearStimulus();
    tReq[0][1] = 1'b1; tDst[0][1] = 5'b00000;
    tReq[0][2] = 1'b1; tDst[0][2] = 5'b00110;
    applyStimulus();
    cycle();
    cycle();
    checkOutput("t5 no grant", 32'(sif.sa_grant_valid), 32'd0);
    checkOutput("t5 no xbar", 32'(sif.xbar_valid), 32'd0);
    clearStimulus();
    for (int v = 0; v < NV; v++) begin tReq[0][v] = 1'b1; tDst[0][v] = NP'(1 << v); end
    applyStimulus();
    cycle();
    checkOutput("t5 grant_vc[0] after bad", 32'(sif.sa_grant_vc[0 +: VB]), 32'd0);

    // Packet of three flits from p1v2 against p3v0, both to output 0
    pulseReset();
    clearStimulus();
    tReq[3][0] = 1'b1; tDst[3][0] = 5'b00001;
`ifdef SA_PACKET_LOCK_EN
    seqA = '{1, 1, 1, 3, 0, 0, 0, 0};
`else
    seqA = '{1, 3, 1, 3, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      tReq[1][2]  = (k < 3);
      tDst[1][2]  = 5'b00001;
      tTail[1][2] = (k == 2);
      applyStimulus();
      cycle();
      checkOutput($sformatf("t6 xbar_sel[0] step%0d", k), 32'(sif.xbar_sel[0 +: PB]), seqA[k]);
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < NP; p++)
        for (int v = 0; v < NV; v++) begin
          int r;
          tReq[p][v] = ($urandom_range(0, 99) < 40);
          r = $urandom_range(0, 9);
          if (r == 0) tDst[p][v] = '0;
          else if (r == 1) tDst[p][v] = NP'($urandom_range(0, 31));
          else tDst[p][v] = NP'(1 << $urandom_range(0, NP - 1));
          tTail[p][v] = ($urandom_range(0, 2) != 0);
        end
      for (int o = 0; o < NP; o++) tReady[o] = ($urandom_range(0, 99) < 80);
      applyStimulus();
      if ($urandom_range(0, 99) == 0) pulseReset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
